bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
Two-master arbiter that shares the single physical memory bus feeding the MMU/memory-mapper path between the CPU (master 0) and a second bus master such as a DMA or video fetch engine (master 1).
- Round-robin grant, held for one complete transaction.
- Per-transaction watchdog that completes a hung access with an error pulse, so neither master deadlocks.
- Sits between the masters and the bus downstream side (s_*); slaves are unchanged.

Parameters:
TIMEOUT, 1024, cycles a granted transaction may wait for s_ready before forced completion; 0 disables the watchdog.
ERR_DATA, 32'h00000000, read data returned to a master on a timed-out transaction.

Ports:
clk  in  1  system clock (clk_main domain)
rst  in  1  synchronous, active-high reset
m0_a  in  32  master 0 address
m0_d  in  32  master 0 write data
m0_we  in  1  master 0 write request (level)
m0_rd  in  1  master 0 read request (level)
m0_spo  out  32  master 0 read data
m0_ready  out  1  master 0 transaction-complete pulse
m1_a, m1_d, m1_we, m1_rd, m1_spo, m1_ready  same as m0_*, for master 1
s_a  out  32  downstream address
s_d  out  32  downstream write data
s_we  out  1  downstream write request
s_rd  out  1  downstream read request
s_spo  in  32  downstream read data
s_ready  in  1  downstream complete pulse
err  out  1  one-cycle pulse on watchdog timeout
err_master  out  1  master index of the last timeout (sticky)
grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Master protocol: a master requests by asserting rd or we (never both). It holds a/d/we/rd stable until its ready is high for one cycle. A master asserting both rd and we is illegal: the arbiter forwards both and behaviour is undefined.
- States:
  - IDLE: grant=00; s_a=0, s_d=0, s_we=0, s_rd=0.
  - G0 / G1: s_* are combinational copies of the granted master's a/d/we/rd.
- IDLE transitions, on the next clock edge:
  - Only m0 requesting -> G0.
  - Only m1 requesting -> G1.
  - Both requesting -> the master not named by the last pointer; the pointer is updated to the granted master.
  - No request -> stay in IDLE.
- Grant latency: a request seen in IDLE at edge N drives s_rd/s_we from cycle N+1.
- Completion in G0/G1:
  - When s_ready=1, the granted master's ready=1 and spo=s_spo combinationally in the same cycle.
  - Next state is IDLE unconditionally, giving a one-cycle turnaround in which s_rd/s_we are low. Back-to-back transactions from one master are therefore at least 2 cycles apart.
- Non-granted master: ready=0 and spo=0 always. The granted master outside completion also has ready=0 and spo=0.
- Watchdog: wcnt clears on entry to G0/G1 and increments each cycle while s_ready=0. If wcnt==TIMEOUT-1 and s_ready=0 (with TIMEOUT!=0):
  - Granted master gets ready=1 and spo=ERR_DATA.
  - err=1 for that cycle; err_master is set to the granted index.
  - Next state is IDLE.
  - If s_ready and the timeout coincide, s_ready wins: normal data is returned and err stays 0.
- Request withdrawn while granted (rd/we drop before ready): the illegal drop is forwarded. The arbiter stays granted until s_ready or timeout.
- Reset (any cycle, including mid-transaction), registered outputs at the next edge:
  - State IDLE, grant=00, err=0, err_master=0, wcnt=0.
  - Last pointer=1, so m0 wins the first contention.
  - All m*_ready=0, m*_spo=0, s_*=0.
- Widths: wcnt is clog2(TIMEOUT+1) bits and does not wrap because it is bounded by the timeout compare. Data and address pass through at full 32 bits unmodified.

Test Plan:
- Single m0 read, a=32'h0000_1000, s_ready 3 cycles after s_rd rises, s_spo=32'hCAFEBABE -> grant=01 the cycle after the request; m0_ready=1 and m0_spo=32'hCAFEBABE in the s_ready cycle; IDLE the next cycle; m1_ready stays 0.
- m0 and m1 both request in the same IDLE cycle after reset -> m0 granted first. After m0 completes: one IDLE cycle, then m1 granted (grant=10). A repeat with both requesting again -> m0 granted.
- m1 write a=32'h2000_0004, d=32'h12345678, slave ready after 1 cycle -> s_we=1, s_a/s_d match while granted; m1_ready pulses exactly once; s_we is 0 in the turnaround cycle.
- TIMEOUT=8, m0 read with s_ready held 0 -> m0_ready=1 and m0_spo=ERR_DATA exactly 8 cycles after grant; err pulses 1 cycle; err_master=0; a subsequent m1 request is served normally.
- s_ready asserted in the same cycle the watchdog would fire (TIMEOUT=8, ready at cycle 8) -> normal s_spo returned, err=0.
- rst asserted while G1 is waiting on a slow slave -> next cycle grant=00, s_rd=0, m1_ready=0. After release, with m0 and m1 both requesting, m0 is granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master round-robin arbiter sharing one downstream memory bus between the
// CPU (master 0) and a second bus master (master 1, e.g. DMA or video fetch).
// A grant is held for one complete transaction and followed by a one-cycle
// IDLE turnaround. A per-transaction watchdog completes a hung access with an
// error pulse so neither master can deadlock on a dead slave.
//
// Parameters
//   TIMEOUT   cycles a granted transaction may wait for s_ready (0 = no watchdog)
//   ERR_DATA  read data returned to a master on a timed-out transaction
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   m0_a/m0_d/m0_we/m0_rd          master 0 request (held until m0_ready)
//   m0_spo/m0_ready                master 0 read data / completion pulse
//   m1_*                           same as m0_* for master 1
//   s_a/s_d/s_we/s_rd              downstream request (copy of granted master)
//   s_spo/s_ready                  downstream read data / completion pulse
//   err                            one-cycle pulse on watchdog timeout
//   err_master                     master index of the last timeout (sticky)
//   grant                          one-hot current owner, 00 when idle
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_a,
   input  logic [31:0] m0_d,
   input  logic        m0_we,
   input  logic        m0_rd,
   output logic [31:0] m0_spo,
   output logic        m0_ready,
   input  logic [31:0] m1_a,
   input  logic [31:0] m1_d,
   input  logic        m1_we,
   input  logic        m1_rd,
   output logic [31:0] m1_spo,
   output logic        m1_ready,
   output logic [31:0] s_a,
   output logic [31:0] s_d,
   output logic        s_we,
   output logic        s_rd,
   input  logic [31:0] s_spo,
   input  logic        s_ready,
   output logic        err,
   output logic        err_master,
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   // Counter wide enough to hold TIMEOUT; a disabled watchdog keeps a 1-bit stub.
   localparam int unsigned    CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit             WDOG_EN   = (TIMEOUT != 0);
   localparam logic [CW-1:0]  WCNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t          state_q;
   logic [1:0]      grant_q;
   logic            last_q;        // index of the most recently granted master
   logic [CW-1:0]   wcnt_q;
   logic            err_master_q;

   logic            req0;
   logic            req1;
   logic            granted;
   logic            timeout_hit;
   logic            done;
   logic [31:0]     rsp_data;

   assign req0 = m0_rd | m0_we;
   assign req1 = m1_rd | m1_we;

   assign grant      = grant_q;
   assign err_master = err_master_q;

   always_comb begin
      granted     = (state_q == G0) || (state_q == G1);
      // A real s_ready in the same cycle beats the watchdog.
      timeout_hit = WDOG_EN && granted && !s_ready && (wcnt_q == WCNT_LAST);
      done        = granted && (s_ready || timeout_hit);
      rsp_data    = s_ready ? s_spo : ERR_DATA;
      err         = timeout_hit;

      // NOTE: every combinational output gets a default before the case so no
      // path leaves it unassigned, which would otherwise infer a latch.
      s_a      = '0;
      s_d      = '0;
      s_we     = 1'b0;
      s_rd     = 1'b0;
      m0_ready = 1'b0;
      m0_spo   = '0;
      m1_ready = 1'b0;
      m1_spo   = '0;

      case (state_q)
         G0: begin
            s_a      = m0_a;
            s_d      = m0_d;
            s_we     = m0_we;
            s_rd     = m0_rd;
            m0_ready = done;
            m0_spo   = done ? rsp_data : '0;
         end
         G1: begin
            s_a      = m1_a;
            s_d      = m1_d;
            s_we     = m1_we;
            s_rd     = m1_rd;
            m1_ready = done;
            m1_spo   = done ? rsp_data : '0;
         end
         default: ;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 2'b00;
         last_q       <= 1'b1;      // m0 wins the first contention after reset
         wcnt_q       <= '0;
         err_master_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               wcnt_q <= '0;        // counter starts from zero on every grant
               if (req0 && (!req1 || last_q)) begin
                  state_q <= G0;
                  grant_q <= 2'b01;
                  last_q  <= 1'b0;
               end else if (req1) begin
                  state_q <= G1;
                  grant_q <= 2'b10;
                  last_q  <= 1'b1;
               end
            end
            G0, G1: begin
               if (done) begin
                  // Unconditional return to IDLE gives the turnaround cycle.
                  state_q <= IDLE;
                  grant_q <= 2'b00;
                  if (timeout_hit) begin
                     err_master_q <= (state_q == G1);
                  end
               end else if (WDOG_EN && !s_ready) begin
                  wcnt_q <= wcnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

endmodule
